// File: rtl/eth_phy_10g_rx_lock_mc.sv
// Per-lane BASE-R block lock, bitslip and BER/link-status monitor; lanes share one 125us window. ETH_PHY_RX_LOCK_LOSS_CNT_EN adds lock-loss counters.
// Latency: header sampled in cycle N affects the registered outputs in N+1. Backpressure: none; hdr_valid low pauses counting.
module eth_phy_10g_rx_lock_mc #(
    parameter int CHANNELS            = 4,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8,
    parameter int COUNT_125US         = 19531,
    parameter int LOCK_GOOD_COUNT     = 64,
    parameter int SLIP_BAD_COUNT      = 16,
    parameter int BER_THRESHOLD       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*CHANNELS-1:0] serdes_rx_hdr,
    input  logic [CHANNELS-1:0]   serdes_rx_hdr_valid,
    output logic [CHANNELS-1:0]   serdes_rx_bitslip,
    output logic [CHANNELS-1:0]   rx_block_lock,
    output logic [CHANNELS-1:0]   rx_high_ber,
    output logic [CHANNELS-1:0]   rx_status,
    output logic                  rx_all_lock,
    output logic [8*CHANNELS-1:0] rx_lock_loss_count
);
    localparam int SHW = $clog2(LOCK_GOOD_COUNT + 1);
    localparam int IVW = $clog2(SLIP_BAD_COUNT + 1);
    localparam int BRW = $clog2(BER_THRESHOLD + 1);
    localparam int TMX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ? BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
    localparam int TMW = $clog2(TMX + 1);
    localparam int WNW = $clog2(COUNT_125US + 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_SLIP_HIGH,
        ST_SLIP_LOW,
        ST_LOCKED
    } lane_state_t;

    logic [WNW-1:0]      win_q;
    logic [WNW-1:0]      win_d;
    logic                win_wrap;
    logic [CHANNELS-1:0] lock_nxt;
    logic                all_lock_q;

    always_comb begin
        win_wrap = (win_q == WNW'(COUNT_125US - 1));
        win_d    = win_wrap ? '0 : win_q + WNW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q      <= '0;
            all_lock_q <= 1'b0;
        end else begin
            win_q      <= win_d;
            all_lock_q <= &lock_nxt;
        end
    end

    assign rx_all_lock = all_lock_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        lane_state_t    state_q;
        logic [SHW-1:0] sh_cnt_q;
        logic [IVW-1:0] invld_q;
        logic [TMW-1:0] tmr_q;
        logic [BRW-1:0] ber_cnt_q;
        logic [BRW-1:0] ber_cnt_d;
        logic [BRW-1:0] ber_sat;
        logic           bitslip_q;
        logic           lock_q;
        logic           high_ber_q;
        logic           high_ber_d;
        logic           status_q;
        logic           status_d;
        logic           clean_q;
        logic           clean_d;
        logic           hdr_vld;
        logic           hdr_ok;
        logic           grp_done;
        logic           acquire;
        logic           ber_hit;
        logic           lock_loss;
        logic           lock_nxt_l;
        logic           win_clean;

        always_comb begin
            hdr_vld    = serdes_rx_hdr_valid[g];
            hdr_ok     = serdes_rx_hdr[2*g] ^ serdes_rx_hdr[2*g+1];
            grp_done   = (sh_cnt_q == SHW'(LOCK_GOOD_COUNT - 1));
            acquire    = (state_q == ST_UNLOCKED) && hdr_vld && hdr_ok && grp_done;
            ber_hit    = (state_q == ST_LOCKED) && hdr_vld && !hdr_ok;
            lock_loss  = ber_hit && (invld_q == IVW'(SLIP_BAD_COUNT - 1));
            lock_nxt_l = acquire || ((state_q == ST_LOCKED) && !lock_loss);

            ber_sat = (ber_cnt_q == BRW'(BER_THRESHOLD)) ? ber_cnt_q : ber_cnt_q + BRW'(ber_hit);
            // A header on the wrap cycle belongs to the window that is just starting.
            if (lock_loss)     ber_cnt_d = '0;
            else if (win_wrap) ber_cnt_d = BRW'(ber_hit);
            else               ber_cnt_d = ber_sat;

            if (win_wrap) high_ber_d = high_ber_q && (ber_cnt_q == BRW'(BER_THRESHOLD));
            else          high_ber_d = high_ber_q || (ber_sat == BRW'(BER_THRESHOLD));

            win_clean = clean_q && (state_q == ST_LOCKED) && !high_ber_q && (ber_cnt_q == '0);
            clean_d   = win_wrap || win_clean;

            if (!lock_nxt_l || high_ber_d)  status_d = 1'b0;
            else if (win_wrap && win_clean) status_d = 1'b1;
            else                            status_d = status_q;
        end

        assign lock_nxt[g] = lock_nxt_l;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= ST_UNLOCKED;
                sh_cnt_q   <= '0;
                invld_q    <= '0;
                tmr_q      <= '0;
                bitslip_q  <= 1'b0;
                lock_q     <= 1'b0;
                ber_cnt_q  <= '0;
                high_ber_q <= 1'b0;
                status_q   <= 1'b0;
                clean_q    <= 1'b0;
            end else begin
                ber_cnt_q  <= ber_cnt_d;
                high_ber_q <= high_ber_d;
                status_q   <= status_d;
                clean_q    <= clean_d;
                case (state_q)
                    ST_UNLOCKED: begin
                        if (hdr_vld) begin
                            if (!hdr_ok) begin
                                state_q   <= ST_SLIP_HIGH;
                                sh_cnt_q  <= '0;
                                tmr_q     <= '0;
                                bitslip_q <= 1'b1;
                            end else if (grp_done) begin
                                state_q  <= ST_LOCKED;
                                lock_q   <= 1'b1;
                                sh_cnt_q <= '0;
                                invld_q  <= '0;
                            end else begin
                                sh_cnt_q <= sh_cnt_q + SHW'(1);
                            end
                        end
                    end
                    ST_SLIP_HIGH: begin
                        if (tmr_q == TMW'(BITSLIP_HIGH_CYCLES - 1)) begin
                            tmr_q     <= '0;
                            bitslip_q <= 1'b0;
                            state_q   <= (BITSLIP_LOW_CYCLES == 0) ? ST_UNLOCKED : ST_SLIP_LOW;
                        end else begin
                            tmr_q <= tmr_q + TMW'(1);
                        end
                    end
                    ST_SLIP_LOW: begin
                        if (tmr_q == TMW'(BITSLIP_LOW_CYCLES - 1)) begin
                            tmr_q   <= '0;
                            state_q <= ST_UNLOCKED;
                        end else begin
                            tmr_q <= tmr_q + TMW'(1);
                        end
                    end
                    ST_LOCKED: begin
                        // Drop takes priority over a group completing on the same header.
                        if (lock_loss) begin
                            state_q   <= ST_SLIP_HIGH;
                            lock_q    <= 1'b0;
                            bitslip_q <= 1'b1;
                            tmr_q     <= '0;
                            sh_cnt_q  <= '0;
                            invld_q   <= '0;
                        end else if (hdr_vld) begin
                            if (grp_done) begin
                                sh_cnt_q <= '0;
                                invld_q  <= '0;
                            end else begin
                                sh_cnt_q <= sh_cnt_q + SHW'(1);
                                invld_q  <= invld_q + IVW'(!hdr_ok);
                            end
                        end
                    end
                    default: state_q <= ST_UNLOCKED;
                endcase
            end
        end

        assign serdes_rx_bitslip[g] = bitslip_q;
        assign rx_block_lock[g]     = lock_q;
        assign rx_high_ber[g]       = high_ber_q;
        assign rx_status[g]         = status_q;

`ifdef ETH_PHY_RX_LOCK_LOSS_CNT_EN
        logic [7:0] loss_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                loss_q <= '0;
            end else if (lock_loss && (loss_q != 8'hff)) begin
                loss_q <= loss_q + 8'd1;
            end
        end

        assign rx_lock_loss_count[8*g +: 8] = loss_q;
`else
        assign rx_lock_loss_count[8*g +: 8] = 8'd0;
`endif
    end

endmodule

// File: tb/tb_eth_phy_10g_rx_lock_mc.sv
// Directed bench for eth_phy_10g_rx_lock_mc: two lanes, 200-cycle BER window.
// Edge index t counts clock edges since reset release, so window wraps land on t%200==199.
module tb_eth_phy_10g_rx_lock_mc;
    localparam int CH = 2;
`ifdef ETH_PHY_RX_LOCK_LOSS_CNT_EN
    localparam logic [7:0] LOSS_EXP = 8'd1;
`else
    localparam logic [7:0] LOSS_EXP = 8'd0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [2*CH-1:0] serdes_rx_hdr;
    logic [CH-1:0]   serdes_rx_hdr_valid;
    logic [CH-1:0]   serdes_rx_bitslip;
    logic [CH-1:0]   rx_block_lock;
    logic [CH-1:0]   rx_high_ber;
    logic [CH-1:0]   rx_status;
    logic            rx_all_lock;
    logic [8*CH-1:0] rx_lock_loss_count;

    int n_vec    = 0;
    int n_miscmp = 0;
    int t        = 0;

    always #5 clk = ~clk;

    eth_phy_10g_rx_lock_mc #(
        .CHANNELS            (CH),
        .BITSLIP_HIGH_CYCLES (1),
        .BITSLIP_LOW_CYCLES  (8),
        .COUNT_125US         (200),
        .LOCK_GOOD_COUNT     (64),
        .SLIP_BAD_COUNT      (16),
        .BER_THRESHOLD       (16)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .serdes_rx_hdr       (serdes_rx_hdr),
        .serdes_rx_hdr_valid (serdes_rx_hdr_valid),
        .serdes_rx_bitslip   (serdes_rx_bitslip),
        .rx_block_lock       (rx_block_lock),
        .rx_high_ber         (rx_high_ber),
        .rx_status           (rx_status),
        .rx_all_lock         (rx_all_lock),
        .rx_lock_loss_count  (rx_lock_loss_count)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic [1:0] h0, input logic v0, input logic [1:0] h1, input logic v1);
        serdes_rx_hdr       = {h1, h0};
        serdes_rx_hdr_valid = {v1, v0};
        @(posedge clk);
        #1;
        t++;
    endtask

    // Lane-0 invalid headers for the BER windows: 15 in window 2, one on the wrap edge 599,
    // then 15 more in window 3 (the 16th of that window lands on edge 712). Spacing 8 keeps lock.
    function automatic logic bad0(input int e);
        return ((e >= 400) && (e <= 512) && ((e - 400) % 8 == 0)) || (e == 599) ||
               ((e >= 600) && (e <= 712) && ((e - 600) % 8 == 0));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [CH-1:0] slip_seen;
        int e;
        rst                 = 1'b1;
        serdes_rx_hdr       = '0;
        serdes_rx_hdr_valid = '0;
        repeat (3) tick(2'b00, 1'b0, 2'b00, 1'b0);
        chk_eq("rst_bitslip", serdes_rx_bitslip, 0);
        chk_eq("rst_lock", rx_block_lock, 0);
        chk_eq("rst_high_ber", rx_high_ber, 0);
        chk_eq("rst_status", rx_status, 0);
        chk_eq("rst_all_lock", rx_all_lock, 0);
        chk_eq("rst_loss_cnt", rx_lock_loss_count, 0);
        rst = 1'b0;
        t   = 0;

        // Lock acquire on lane 0; lane 1 paused.
        repeat (63) tick(2'b01, 1'b1, 2'b01, 1'b0);
        chk_eq("lock_after_63", rx_block_lock, 2'b00);
        tick(2'b01, 1'b1, 2'b01, 1'b0);
        chk_eq("lock_after_64", rx_block_lock, 2'b01);
        chk_eq("all_lock_one_lane", rx_all_lock, 0);

        // Slip timing on lane 1.
        tick(2'b01, 1'b1, 2'b11, 1'b1);
        chk_eq("slip_pulse", serdes_rx_bitslip, 2'b10);
        slip_seen = '0;
        repeat (9) begin
            tick(2'b01, 1'b1, 2'b00, 1'b1);
            slip_seen |= serdes_rx_bitslip;
        end
        chk_eq("holdoff_no_slip", slip_seen, 2'b00);
        tick(2'b01, 1'b1, 2'b00, 1'b1);
        chk_eq("slip_after_holdoff", serdes_rx_bitslip, 2'b10);

        // Gearbox pause with garbage headers.
        repeat (10) tick(2'b11, 1'b0, 2'b11, 1'b0);
        chk_eq("pause_lock", rx_block_lock, 2'b01);
        chk_eq("pause_bitslip", serdes_rx_bitslip, 2'b00);
        chk_eq("pause_high_ber", rx_high_ber, 2'b00);

        // BER windows on lane 0, edges 85..1199.
        while (t < 1200) begin
            e = t;
            tick(bad0(e) ? 2'b11 : 2'b01, 1'b1, 2'b01, 1'b0);
            case (e)
                199: chk_eq("status_w0_end", rx_status, 2'b00);
                398: chk_eq("status_w1_before_wrap", rx_status, 2'b00);
                399: chk_eq("status_w1_wrap", rx_status, 2'b01);
                599: begin
                    chk_eq("high_ber_15_bad", rx_high_ber, 2'b00);
                    chk_eq("lock_15_bad_window", rx_block_lock, 2'b01);
                end
                711: begin
                    chk_eq("high_ber_w3_15", rx_high_ber, 2'b00);
                    chk_eq("status_w3_15", rx_status, 2'b01);
                end
                714: begin
                    chk_eq("high_ber_w3_16", rx_high_ber, 2'b01);
                    chk_eq("status_high_ber", rx_status, 2'b00);
                    chk_eq("lock_high_ber", rx_block_lock, 2'b01);
                end
                799: chk_eq("high_ber_held_wrap", rx_high_ber, 2'b01);
                998: chk_eq("high_ber_before_clean_wrap", rx_high_ber, 2'b01);
                999: begin
                    chk_eq("high_ber_clean_wrap", rx_high_ber, 2'b00);
                    chk_eq("status_clean_wrap", rx_status, 2'b00);
                end
                1198: chk_eq("status_w5_before_wrap", rx_status, 2'b00);
                1199: begin
                    chk_eq("status_w5_wrap", rx_status, 2'b01);
                    chk_eq("lock_w5", rx_block_lock, 2'b01);
                end
                default: ;
            endcase
        end

        // Lock loss: lane 0 group sits at 38 headers, so 16 bad headers fit in one group.
        repeat (15) tick(2'b11, 1'b1, 2'b01, 1'b0);
        chk_eq("lock_15_bad_hdrs", rx_block_lock, 2'b01);
        chk_eq("no_slip_15_bad", serdes_rx_bitslip, 2'b00);
        tick(2'b11, 1'b1, 2'b01, 1'b0);
        chk_eq("lock_drop", rx_block_lock, 2'b00);
        chk_eq("loss_slip", serdes_rx_bitslip, 2'b01);
        chk_eq("loss_status", rx_status, 2'b00);
        chk_eq("loss_all_lock", rx_all_lock, 0);
        chk_eq("loss_cnt_lane0", rx_lock_loss_count[7:0], LOSS_EXP);
        chk_eq("loss_cnt_lane1", rx_lock_loss_count[15:8], 0);
        tick(2'b01, 1'b1, 2'b01, 1'b0);
        chk_eq("loss_slip_one_cycle", serdes_rx_bitslip, 2'b00);
        repeat (71) tick(2'b01, 1'b1, 2'b01, 1'b0);
        chk_eq("relock_63", rx_block_lock, 2'b00);
        tick(2'b01, 1'b1, 2'b01, 1'b0);
        chk_eq("relock_64", rx_block_lock, 2'b01);

        // Reset with lane 0 locked and lane 1 in SLIP_HIGH.
        tick(2'b01, 1'b1, 2'b00, 1'b1);
        chk_eq("pre_rst_slip", serdes_rx_bitslip, 2'b10);
        rst = 1'b1;
        tick(2'b01, 1'b1, 2'b00, 1'b1);
        chk_eq("mid_rst_bitslip", serdes_rx_bitslip, 0);
        chk_eq("mid_rst_lock", rx_block_lock, 0);
        chk_eq("mid_rst_high_ber", rx_high_ber, 0);
        chk_eq("mid_rst_status", rx_status, 0);
        chk_eq("mid_rst_all_lock", rx_all_lock, 0);
        chk_eq("mid_rst_loss_cnt", rx_lock_loss_count, 0);
        rst = 1'b0;
        t   = 0;
        repeat (63) tick(2'b01, 1'b1, 2'b10, 1'b1);
        chk_eq("post_rst_lock_63", rx_block_lock, 2'b00);
        tick(2'b01, 1'b1, 2'b10, 1'b1);
        chk_eq("post_rst_lock_64", rx_block_lock, 2'b11);
        chk_eq("post_rst_all_lock", rx_all_lock, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule

// File: doc/eth_phy_10g_rx_lock_mc.md
# eth_phy_10g_rx_lock_mc

Multi-lane BASE-R receive alignment and link-health monitor. For each of CHANNELS lanes it watches the 2-bit sync headers from the SERDES gearbox and drives the lane's bitslip request until 64b/66b block lock is reached. It also tracks the per-lane bit error rate over a shared 125 us window and produces per-lane lock, high-BER and link-status flags. It sits between the SERDES/gearbox and the per-lane PCS receive path, replacing the single-lane lock/BER logic inside the 10G PHY receive path.

## Interface
- CHANNELS, 4: number of independent lanes (1-16).
- BITSLIP_HIGH_CYCLES, 1: cycles the bitslip output is held high per slip (>=1).
- BITSLIP_LOW_CYCLES, 8: holdoff cycles after each slip; headers are ignored during holdoff (>=0).
- COUNT_125US, 19531: clk cycles per BER window, minus nothing (window length = COUNT_125US cycles).
- LOCK_GOOD_COUNT, 64: consecutive valid headers required to acquire lock.
- SLIP_BAD_COUNT, 16: invalid headers within one LOCK_GOOD_COUNT group that drop lock.
- BER_THRESHOLD, 16: invalid headers within one window that assert high BER.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- serdes_rx_hdr  in  2*CHANNELS  sync header, lane n at [2n+1:2n].
- serdes_rx_hdr_valid  in  CHANNELS  header on lane n is meaningful this cycle (gearbox pause when low).
- serdes_rx_bitslip  out  CHANNELS  bitslip request to the SERDES.
- rx_block_lock  out  CHANNELS  lane block lock.
- rx_high_ber  out  CHANNELS  lane high-BER flag.
- rx_status  out  CHANNELS  lane link good.
- rx_all_lock  out  1  AND of all rx_block_lock bits.
- rx_lock_loss_count  out  8*CHANNELS  saturating lock-loss counter per lane (see Configuration).

## Operation
- Valid header: 2'b01 or 2'b10; 2'b00/2'b11 are invalid. A header counts only when the corresponding hdr_valid is high and the lane is in UNLOCKED or LOCKED.
- Per-lane FSM, four states:
  - UNLOCKED: each counted valid header increments sh_cnt. When sh_cnt reaches LOCK_GOOD_COUNT, go to LOCKED and clear the counters. Any invalid header clears sh_cnt and goes to SLIP_HIGH.
  - SLIP_HIGH: bitslip=1 for BITSLIP_HIGH_CYCLES, then go to SLIP_LOW.
  - SLIP_LOW: bitslip=0 for BITSLIP_LOW_CYCLES, then go to UNLOCKED. If BITSLIP_LOW_CYCLES=0, go to UNLOCKED directly.
  - LOCKED: each counted header increments sh_cnt; each invalid header also increments sh_invld_cnt.
    - If sh_invld_cnt reaches SLIP_BAD_COUNT, go to SLIP_HIGH, drop lock and clear the counters.
    - Otherwise, when sh_cnt reaches LOCK_GOOD_COUNT, clear both counters and stay in LOCKED.
    - If both conditions occur on the same header, the drop wins.
- rx_block_lock = (state==LOCKED), registered.
- BER: one shared free-running window counter runs 0..COUNT_125US-1 and produces a wrap pulse at the terminal count.
  - Per lane, ber_cnt counts invalid headers while LOCKED and saturates at BER_THRESHOLD.
  - rx_high_ber sets the cycle after ber_cnt reaches BER_THRESHOLD.
  - On the wrap pulse, ber_cnt clears. rx_high_ber also clears if the count was below threshold.
  - An invalid header coincident with the wrap is counted in the new window (ber_cnt becomes 1).
  - Lock loss clears ber_cnt but does not clear rx_high_ber.
- rx_status:
  - Clears the cycle after rx_block_lock or rx_high_ber would be 0/1 respectively.
  - Sets on a wrap pulse if the lane was LOCKED, not high-BER and had ber_cnt==0 for the entire window just ended.
- Lanes are fully independent except for the shared window counter.

## Timing
- All outputs are registered. Header sampled in cycle N gives its lock/bitslip/BER effect on outputs in cycle N+1.
- Worst-case lock time per lane: LOCK_GOOD_COUNT counted headers after the last slip holdoff.
- Reset: all outputs 0; all FSMs UNLOCKED; all counters 0; window counter 0.
- Reset mid-slip: bitslip drops to 0 the cycle after rst is sampled high.
- Headers with hdr_valid=0 freeze sh_cnt/sh_invld_cnt and the FSM in UNLOCKED/LOCKED. The SLIP_HIGH/SLIP_LOW timers count clk cycles regardless of hdr_valid.

## Configuration
- ETH_PHY_RX_LOCK_LOSS_CNT_EN defined: rx_lock_loss_count lane n increments on each LOCKED->SLIP_HIGH transition, saturates at 255, and clears only on rst.
- Not defined: no counter registers are built and rx_lock_loss_count is tied to 0. All other behaviour is identical.

## Test plan
Bench parameters: CHANNELS=2, BITSLIP_HIGH_CYCLES=1, BITSLIP_LOW_CYCLES=8, COUNT_125US=200, LOCK_GOOD_COUNT=64, SLIP_BAD_COUNT=16, BER_THRESHOLD=16.
- Lock acquire: 64 headers of 2'b01 on lane 0 with hdr_valid=1 -> rx_block_lock[0]=1 one cycle after the 64th header; lane 1 stays 0; rx_all_lock=0.
- Slip timing: one 2'b11 header on unlocked lane 1 -> bitslip[1]=1 for exactly 1 cycle, then 8 cycles of holdoff during which 2'b00 headers cause no further slip.
- Lock loss: on locked lane 0, 16 invalid headers within a 64-header group -> lock drops, one bitslip pulse. With the macro, rx_lock_loss_count[7:0]=1; without it, 0.
- High BER: 15 invalid headers spread over one window -> rx_high_ber=0 and lock held. Next window, 16 invalid headers -> rx_high_ber=1 and rx_status=0. Following clean window -> rx_high_ber=0 at wrap, rx_status=1 at the next wrap.
- Gearbox pause: hdr_valid=0 for 10 cycles with garbage headers on a locked lane -> no counter change, lock kept.
- Reset mid-operation: rst asserted while lane 0 is LOCKED and lane 1 is in SLIP_HIGH -> next cycle all outputs 0, and re-lock requires a fresh 64 valid headers.
